// File: rtl/data_mem_wait.sv
// data_mem_wait: single-port word-organised data memory with RV32I byte/half/word
// access, misalignment detection and a fixed number of wait states per access.
// One request is in flight at a time. A request is accepted in IDLE and answered
// with a one-cycle resp_valid strobe; there is no response backpressure.
module data_mem_wait #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic [31:0] read_data,
  output logic        misaligned
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;

  // Request fields captured at the accept edge, used while waiting.
  logic              wr_q;
  logic [2:0]        f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       mem [DEPTH];

  // Bits above the word index only alias the same storage.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  logic              in_idle;
  logic              accept;
  logic              acc_wr;
  logic [2:0]        acc_f3;
  logic [ADDR_W+1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_err;
  logic              commit;
  logic [31:0]       cur_word;
  logic [31:0]       store_word;
  logic [31:0]       load_data;

  assign in_idle   = (state == S_IDLE);
  assign req_ready = in_idle;
  assign accept    = req_valid & req_ready;

  // In IDLE the access fields come straight from the ports (zero-wait and error
  // paths act on the accept edge); otherwise from the captured request.
  assign acc_wr    = in_idle ? mem_write             : wr_q;
  assign acc_f3    = in_idle ? funct3                : f3_q;
  assign acc_addr  = in_idle ? addr[ADDR_W+1:0]      : addr_q;
  assign acc_wdata = in_idle ? write_data            : wdata_q;
  assign acc_idx   = acc_addr[ADDR_W+1:2];
  assign cur_word  = mem[acc_idx];

  // Illegal size code for the direction, or address not aligned to the size.
  function automatic logic access_error(input logic wr, input logic [2:0] f3,
                                        input logic [1:0] a);
    logic err;
    err = 1'b1;
    case (f3)
      3'd0:    err = 1'b0;
      3'd1:    err = a[0];
      3'd2:    err = |a;
      3'd4:    err = wr;
      3'd5:    err = wr | a[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  assign acc_err = access_error(acc_wr, acc_f3, acc_addr[1:0]);

  // The memory is touched exactly on the edge that enters RESP for a legal request.
  assign commit = (in_idle && accept && !acc_err && (WAIT_CYCLES == 0)) ||
                  ((state == S_WAIT) && (cnt == 4'd1));

  // Merge store data into the addressed lanes, leaving the other lanes intact.
  // NOTE: every variable assigned here gets a default first, so no latch is inferred.
  always_comb begin
    store_word = cur_word;
    case (acc_f3[1:0])
      2'd0:    store_word[{acc_addr[1:0], 3'b000} +: 8] = acc_wdata[7:0];
      2'd1:    store_word[{acc_addr[1], 4'b0000} +: 16] = acc_wdata[15:0];
      default: store_word = acc_wdata;
    endcase
  end

  // Select the addressed lane and sign- or zero-extend it.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b         = cur_word[{acc_addr[1:0], 3'b000} +: 8];
    h         = acc_addr[1] ? cur_word[31:16] : cur_word[15:0];
    load_data = '0;
    case (acc_f3)
      3'd0:    load_data = {{24{b[7]}}, b};
      3'd1:    load_data = {{16{h[15]}}, h};
      3'd2:    load_data = cur_word;
      3'd4:    load_data = {24'b0, b};
      3'd5:    load_data = {16'b0, h};
      default: load_data = '0;
    endcase
  end

  // Store commit into the array.
  // NOTE: the storage array is deliberately not reset; contents survive rst and
  // resetting it would turn the RAM into a flop bank.
  always_ff @(posedge clk) begin
    if (commit && acc_wr) mem[acc_idx] <= store_word;
  end

  // Request FSM, wait-state counter, request capture and registered response.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      wr_q       <= 1'b0;
      f3_q       <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      misaligned <= 1'b0;
      read_data  <= '0;
    end else begin
      resp_valid <= 1'b0;
      misaligned <= 1'b0;
      read_data  <= '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            wr_q    <= mem_write;
            f3_q    <= funct3;
            addr_q  <= addr[ADDR_W+1:0];
            wdata_q <= write_data;
            if (acc_err) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              misaligned <= 1'b1;
            end else if (WAIT_CYCLES == 0) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              read_data  <= acc_wr ? 32'd0 : load_data;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) begin
            state      <= S_RESP;
            cnt        <= 4'd0;
            resp_valid <= 1'b1;
            read_data  <= acc_wr ? 32'd0 : load_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_mem_wait.md
DATA_MEM_WAIT -- requirements
Module: data_mem_wait

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, number of word-index bits; depth = 2**ADDR_W 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, range 0..15, number of wait states per aligned access.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port mem_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port funct3  input  3  RV32I access size/sign code.
REQ-009 SHALL have port addr  input  32  byte address.
REQ-010 SHALL have port write_data  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-012 SHALL have port read_data  output  32  load result, extended.
REQ-013 SHALL have port misaligned  output  1  error flag, valid with resp_valid.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-015 Handshake: request accepted on a rising edge where req_valid & req_ready; mem_write, funct3, addr, write_data latched on that edge; req_valid while req_ready = 0 ignored.
REQ-016 Store codes: 0 SB, 1 SH, 2 SW; load codes: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; all other codes are errors.
REQ-017 Error = illegal code, or halfword with addr[0] = 1, or word with addr[1:0] != 0.
REQ-018 On an error request: IDLE -> RESP at accept edge; no memory write; resp_valid = 1, misaligned = 1, read_data = 0 for one cycle.
REQ-019 On a legal request: IDLE -> WAIT if WAIT_CYCLES > 0, else IDLE -> RESP; WAIT lasts exactly WAIT_CYCLES cycles via down-counter, then -> RESP.
REQ-020 Memory access (store commit and load capture) occurs on the edge entering RESP; resp_valid is high during the cycle after that edge, i.e. WAIT_CYCLES+1 cycles after the request cycle.
REQ-021 RESP lasts exactly one cycle, then -> IDLE; no response backpressure; next request accepted no earlier than one cycle after RESP.
REQ-022 Word index = addr[ADDR_W+1:2]; upper address bits ignored, so addresses wrap modulo 4*2**ADDR_W bytes.
REQ-023 SB writes write_data[7:0] to byte lane addr[1:0]; SH writes write_data[15:0] to half addr[1]; SW writes all 32 bits; unselected lanes unchanged.
REQ-024 LB/LH sign-extend, LBU/LHU zero-extend the selected lane to 32 bits; LW returns the word.
REQ-025 read_data = 0 and misaligned = 0 whenever resp_valid = 0; stores respond with read_data = 0.

Reset
REQ-026 rst SHALL immediately force state IDLE, counter 0, req_ready = 1, resp_valid = 0, read_data = 0, misaligned = 0.
REQ-027 Reset SHALL NOT clear memory contents; a store whose commit edge has not occurred when rst asserts SHALL be discarded.

Verification (WAIT_CYCLES = 2, ADDR_W = 8)
REQ-028 SW 0xABCDDEAD @0x0, then LW @0x0 -> resp_valid exactly 3 cycles after each request cycle; load read_data = 0xABCDDEAD, misaligned = 0.
REQ-029 SW 0xA1B2C3D4 @0x4, SB 0x000000EF @0x5 -> LW @0x4 = 0xA1B2EFD4, LB @0x5 = 0xFFFFFFEF, LBU @0x5 = 0x000000EF.
REQ-030 SH 0x00008001 @0xA -> LH @0xA = 0xFFFF8001, LHU @0xA = 0x00008001, LW @0x8 upper half = 0x8001.
REQ-031 LW @0x2, SW @0x6, funct3 = 3 load @0x0 -> each responds 1 cycle after accept with misaligned = 1, read_data = 0; subsequent LW @0x4 still returns 0xA1B2EFD4.
REQ-032 SW 0x0 @0x10, then SW 0x12345678 @0x10 with rst pulsed during WAIT -> outputs at reset values while rst high; later LW @0x10 = 0x00000000.
REQ-033 req_valid held high for back-to-back SW 0x55AA55AA @0x400 then LW @0x0 -> req_ready low through WAIT/RESP, second accept only in IDLE, LW returns 0x55AA55AA (wrap alias).
